// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider with valid/ready handshakes.
//
// Resolves one quotient bit per clock using an N+1-bit trial subtraction.
// A request accepted in IDLE loads the operands. Each of the following N
// cycles in CALC performs one shift/subtract step. The result is then held in
// DONE until the consumer takes it.
//
// Optional build macro: SIGNED_DIV_EN.
//   Defined   - operands are two's complement. Magnitudes are divided and the
//               signs are fixed up on the CALC->DONE edge.
//   Undefined - unsigned division only, and no sign logic is built.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_valid  request valid
//   start_ready  request can be accepted (IDLE only)
//   dividend     numerator, sampled on accept
//   divisor      denominator, sampled on accept
//   done_valid   result valid, held until consumed
//   done_ready   consumer accepts the result
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered flag: divisor was zero
//   busy         high in CALC or DONE
//
// state | meaning
// IDLE  | waiting for a request, start_ready high
// CALC  | one restoring step per cycle, N cycles
// DONE  | result presented, waiting for done_ready
module seq_divider #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         done_valid,
  input  logic         done_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [N-1:0]  q_work;
  logic [N-1:0]  dvsr;
  // The partial remainder stays below the divisor, so its stored form needs
  // only N bits. The (N+1)-th bit exists only in the shifted trial value.
  logic [N-1:0]  rem_work;
  logic [N:0]    rem_shift;
  logic [N:0]    diff;
  logic [N-1:0]  rem_nxt;
  logic [N-1:0]  q_nxt;
  logic [N-1:0]  dvnd_mag;
  logic [N-1:0]  dvsr_mag;
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;
  logic          accept;

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done_valid  = (state == DONE);
  assign accept      = start_valid & start_ready;

  always_comb begin
    rem_shift = {rem_work, q_work[N-1]};
    diff      = rem_shift - {1'b0, dvsr};
    rem_nxt   = diff[N] ? rem_shift[N-1:0] : diff[N-1:0];
    q_nxt     = {q_work[N-2:0], ~diff[N]};
  end

`ifdef SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;

  assign dvnd_mag = dividend[N-1] ? -dividend : dividend;
  assign dvsr_mag = divisor[N-1]  ? -divisor  : divisor;
  // Truncation toward zero: divide the magnitudes, then negate as needed.
  // The most-negative / -1 case yields 2^(N-1) with no negation, which is
  // exactly the most-negative value.
  assign q_fix    = neg_q ? -q_nxt   : q_nxt;
  assign r_fix    = neg_r ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[N-1] ^ divisor[N-1];
      neg_r <= dividend[N-1];
    end
  end
`else
  assign dvnd_mag = dividend;
  assign dvsr_mag = divisor;
  assign q_fix    = q_nxt;
  assign r_fix    = rem_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (count == '0) state_nxt = DONE;
      DONE: if (done_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      q_work      <= '0;
      dvsr        <= '0;
      rem_work    <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvsr     <= dvsr_mag;
      q_work   <= dvnd_mag;
      rem_work <= '0;
      count    <= CNT_LAST;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      rem_work <= rem_nxt;
      q_work   <= q_nxt;
      count    <= count - CNT_ONE;
      if (count == '0) begin
        quotient    <= q_fix;
        remainder   <= r_fix;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed, table-driven bench for seq_divider (N=16), with hand-written
// sequences for backpressure and reset during a calculation.
module tb_seq_divider;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         done_valid;
  logic         done_ready = 1'b0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  seq_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .dividend(dividend), .divisor(divisor),
    .done_valid(done_valid), .done_ready(done_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic run_op(input string tag, input vec_t v);
    int edges;
    check({tag, " start_ready"}, {31'd0, start_ready}, 32'd1);
    dividend    = v.a;
    divisor     = v.b;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    dividend    = 16'($urandom);
    divisor     = 16'($urandom);
    edges = 1;
    while (!done_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, edges, v.dbz ? 32'd1 : 32'(N + 1));
    check({tag, " quotient"}, {16'd0, quotient}, {16'd0, v.q});
    check({tag, " remainder"}, {16'd0, remainder}, {16'd0, v.r});
    check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, v.dbz});
    check({tag, " busy_done"}, {31'd0, busy}, 32'd1);
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    check({tag, " done_valid_cleared"}, {31'd0, done_valid}, 32'd0);
    check({tag, " ready_after"}, {31'd0, start_ready}, 32'd1);
    check({tag, " quotient_kept"}, {16'd0, quotient}, {16'd0, v.q});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    vec_t rv;
`ifdef SIGNED_DIV_EN
    vecs[0] = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0};
    vecs[1] = '{16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0};
    vecs[2] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
    vecs[3] = '{16'd7,    16'hFFFE, 16'hFFFD, 16'd1,    1'b0};
    vecs[4] = '{16'h1234, 16'd0,    16'hFFFF, 16'h1234, 1'b1};
    vecs[5] = '{16'hFF9C, 16'd0,    16'hFFFF, 16'hFF9C, 1'b1};
    vecs[6] = '{16'd5,    16'd9,    16'd0,    16'd5,    1'b0};
    rv      = '{16'd60000, 16'd300, 16'hFFEE, 16'hFF78, 1'b0};
`else
    vecs[0] = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0};
    vecs[1] = '{16'h1234, 16'd0,    16'hFFFF, 16'h1234, 1'b1};
    vecs[2] = '{16'd5,    16'd9,    16'd0,    16'd5,    1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 16'd1,    16'd0,    1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 16'd1,    16'd0,    1'b0};
    vecs[5] = '{16'd1000, 16'd3,    16'd333,  16'd1,    1'b0};
    vecs[6] = '{16'd7,    16'd1000, 16'd0,    16'd7,    1'b0};
    rv      = '{16'd60000, 16'd300, 16'd200,  16'd0,    1'b0};
`endif

    #3;
    check("reset quotient", {16'd0, quotient}, 32'd0);
    check("reset remainder", {16'd0, remainder}, 32'd0);
    check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    check("reset done_valid", {31'd0, done_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset start_ready", {31'd0, start_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: start_valid stays high throughout with different operands,
    // so a second accept would show up as a changed result or busy state.
    dividend    = 16'hFFFF;
    divisor     = 16'd1;
    start_valid = 1'b1;
    done_ready  = 1'b0;
    @(posedge clk); #1;
    dividend = 16'd3;
    divisor  = 16'd1;
    edges = 1;
    while (!done_valid && edges < 40) begin
      check("bp start_ready in calc", {31'd0, start_ready}, 32'd0);
      @(posedge clk); #1;
      edges++;
    end
    check("bp latency", edges, 32'(N + 1));
    for (int i = 0; i < 10; i++) begin
      check("bp done_valid held", {31'd0, done_valid}, 32'd1);
      check("bp quotient held", {16'd0, quotient}, 32'h0000FFFF);
      check("bp remainder held", {16'd0, remainder}, 32'd0);
      check("bp start_ready in done", {31'd0, start_ready}, 32'd0);
      @(posedge clk); #1;
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    done_ready  = 1'b0;
    check("bp consumed done_valid", {31'd0, done_valid}, 32'd0);
    check("bp consumed start_ready", {31'd0, start_ready}, 32'd1);
    check("bp consumed busy", {31'd0, busy}, 32'd0);
    check("bp quotient after consume", {16'd0, quotient}, 32'h0000FFFF);
    @(posedge clk); #1;
    check("bp no second op", {31'd0, busy}, 32'd0);

    // Reset in the middle of a calculation.
    dividend    = rv.a;
    divisor     = rv.b;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid busy before reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-reset quotient", {16'd0, quotient}, 32'd0);
    check("mid-reset remainder", {16'd0, remainder}, 32'd0);
    check("mid-reset done_valid", {31'd0, done_valid}, 32'd0);
    check("mid-reset busy", {31'd0, busy}, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid-reset no done", {31'd0, done_valid}, 32'd0);
    check("mid-reset idle", {31'd0, start_ready}, 32'd1);
    run_op("after-reset", rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
